approx_mul_sweep_ctrl: RTL

//  Exhaustive-sweep controller for a combinational approximate multiplier (IN_W inputs, IN_W outputs).
//  - Drives every input vector into the attached DUT in turn and samples its output after a settle window.
//  - Compares each sample against the exact product and reports max error, violation count and pass/fail vs ET.
//  - Sits beside the approximate-circuit netlist as an in-fabric error-threshold checker.

---
 rtl/approx_mul_sweep_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/approx_mul_sweep_ctrl.sv
// approx_mul_sweep_ctrl: exhaustive-sweep error checker for a combinational approximate multiplier.
// Latency: done pulses 2^IN_W*(SETTLE+1) cycles after the accepting start edge; one vector per SETTLE+1 cycles.
// Backpressure: none; start is only honoured in IDLE, ignored while busy or in DONE.
//
// Ports:
//   clk, rst (sync, active-high)      start  -> begin a sweep
//   busy, done                        sweep in progress / one-cycle completion pulse
//   dut_in -> multiplier,             dut_out <- multiplier (unsigned, IN_W bits)
//   max_err, viol_cnt, first_fail, pass : results, held from DONE until next start or rst
//   err_sum                           sum of abs_err, present only when SUM_ERR_EN is defined
// Optional feature macro: SUM_ERR_EN
module approx_mul_sweep_ctrl #(
  parameter int IN_W   = 4,
  parameter int ET     = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IN_W-1:0]   dut_in,
  input  logic [IN_W-1:0]   dut_out,
  output logic [IN_W-1:0]   max_err,
  output logic [IN_W:0]     viol_cnt,
  output logic [IN_W-1:0]   first_fail,
  output logic              pass
`ifdef SUM_ERR_EN
  ,
  output logic [2*IN_W-1:0] err_sum
`endif
);

  localparam int HALF  = IN_W / 2;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [IN_W-1:0]  LAST_VEC = {IN_W{1'b1}};
  localparam logic [IN_W:0]    ET_V     = (IN_W+1)'(ET);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic [IN_W-1:0]  max_err_q, max_err_d;
  logic [IN_W:0]    viol_q, viol_d;
  logic [IN_W-1:0]  first_q, first_d;
  logic             pass_q, pass_d;
`ifdef SUM_ERR_EN
  logic [2*IN_W-1:0] sum_q, sum_d;
`endif

  // Exact reference product; operands zero-extended so the product is IN_W bits wide.
  logic [IN_W-1:0] op_a, op_b, exact, abs_err;
  logic            is_viol;

  always_comb begin
    op_a    = {{(IN_W-HALF){1'b0}}, dut_in_q[HALF-1:0]};
    op_b    = {{(IN_W-HALF){1'b0}}, dut_in_q[IN_W-1:HALF]};
    exact   = op_a * op_b;
    abs_err = (dut_out >= exact) ? (dut_out - exact) : (exact - dut_out);
    is_viol = ({1'b0, abs_err} > ET_V);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dut_in_d  = dut_in_q;
    max_err_d = max_err_q;
    viol_d    = viol_q;
    first_d   = first_q;
    pass_d    = pass_q;
`ifdef SUM_ERR_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_DRIVE;
          cnt_d     = '0;
          dut_in_d  = '0;
          max_err_d = '0;
          viol_d    = '0;
          first_d   = '0;
          pass_d    = 1'b0;
`ifdef SUM_ERR_EN
          sum_d     = '0;
`endif
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (abs_err > max_err_q) max_err_d = abs_err;
        if (is_viol) begin
          viol_d = viol_q + 1'b1;
          if (viol_q == '0) first_d = dut_in_q;
        end
`ifdef SUM_ERR_EN
        sum_d = sum_q + {{IN_W{1'b0}}, abs_err};
`endif
        // Increment wraps the last vector back to 0, leaving dut_in idle at 0.
        dut_in_d = dut_in_q + 1'b1;
        if (dut_in_q == LAST_VEC) begin
          state_d = ST_DONE;
          pass_d  = (viol_d == '0);
        end else begin
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dut_in_q  <= '0;
      max_err_q <= '0;
      viol_q    <= '0;
      first_q   <= '0;
      pass_q    <= 1'b0;
`ifdef SUM_ERR_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dut_in_q  <= dut_in_d;
      max_err_q <= max_err_d;
      viol_q    <= viol_d;
      first_q   <= first_d;
      pass_q    <= pass_d;
`ifdef SUM_ERR_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign busy       = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign done       = (state_q == ST_DONE);
  assign dut_in     = dut_in_q;
  assign max_err    = max_err_q;
  assign viol_cnt   = viol_q;
  assign first_fail = first_q;
  assign pass       = pass_q;
`ifdef SUM_ERR_EN
  assign err_sum    = sum_q;
`endif

endmodule
